// File: rtl/tile_layer_renderer_pkg.sv
// Shared types and address helpers for the tile layer renderer.
package render_pkg;

  // Render FSM states, in the order a pixel normally visits them.
  typedef enum logic [3:0] {
    S_IDLE,
    S_MAP_REQ,
    S_MAP_WAIT,
    S_SPR_SEL,
    S_TEX_REQ,
    S_TEX_WAIT,
    S_KEY_REQ,
    S_KEY_WAIT,
    S_WRITE
  } state_t;

  // Magenta is the transparent sprite texel unless overridden.
  localparam logic [15:0] DEFAULT_KEY_COLOUR = 16'hF81F;

  // Texel address: id*TILE*TILE + py*TILE + px, with TILE = 1 << tile_bits.
  function automatic logic [31:0] tex_addr_calc(input logic [31:0] id,
                                                input logic [31:0] py,
                                                input logic [31:0] px,
                                                input int          tile_bits);
    return (id << (2 * tile_bits)) + (py << tile_bits) + px;
  endfunction

  // Frame-buffer address: (gy*TILE+py)*fb_w + gx*TILE + px.
  function automatic logic [31:0] dst_addr_calc(input logic [31:0] gx,
                                                input logic [31:0] gy,
                                                input logic [31:0] px,
                                                input logic [31:0] py,
                                                input int          tile_bits,
                                                input int          fb_w);
    return ((gy << tile_bits) + py) * 32'(fb_w) + (gx << tile_bits) + px;
  endfunction

endpackage

// File: rtl/tile_layer_renderer_if.sv
// Memory-side bus of the renderer: map read, texture read, frame-buffer write.
interface tile_layer_renderer_if #(
  parameter int AW    = 19,
  parameter int PIX_W = 16
);
  logic [AW-1:0]    map_addr;
  logic [15:0]      map_data;
  logic [AW-1:0]    tex_addr;
  logic [PIX_W-1:0] tex_data;
  logic [AW-1:0]    dst_addr;
  logic [PIX_W-1:0] dst_data;
  logic             dst_wr;
  logic             dst_ready;

  modport master (
    output map_addr, input map_data,
    output tex_addr, input tex_data,
    output dst_addr, output dst_data, output dst_wr, input dst_ready
  );

  modport slave (
    input map_addr, output map_data,
    input tex_addr, output tex_data,
    input dst_addr, input dst_data, input dst_wr, output dst_ready
  );
endinterface

// File: rtl/tile_layer_renderer_sprite_hit_select.sv
// Priority match of the current map cell against the sprite snapshot;
// the lowest-index enabled sprite sitting on the cell wins.
module sprite_hit_select #(
  parameter int NUM_SPRITES = 4,
  parameter int GRID_BITS   = 4,
  parameter int MAP_W       = 16,
  parameter int MAP_H       = 12
) (
  input  logic [NUM_SPRITES-1:0]           spr_en_i,
  input  logic [NUM_SPRITES*GRID_BITS-1:0] spr_x_i,
  input  logic [NUM_SPRITES*GRID_BITS-1:0] spr_y_i,
  input  logic [NUM_SPRITES*16-1:0]        spr_tile_i,
  input  logic [GRID_BITS-1:0]             gx_i,
  input  logic [GRID_BITS-1:0]             gy_i,
  output logic                             hit_o,
  output logic [15:0]                      tile_o
);

  logic [NUM_SPRITES-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_match
      logic [GRID_BITS-1:0] sx;
      logic [GRID_BITS-1:0] sy;
      assign sx = spr_x_i[gi*GRID_BITS +: GRID_BITS];
      assign sy = spr_y_i[gi*GRID_BITS +: GRID_BITS];
      // Off-map sprite coordinates are rejected explicitly.
      assign match[gi] = spr_en_i[gi] && (32'(sx) < MAP_W) && (32'(sy) < MAP_H) &&
                         (sx == gx_i) && (sy == gy_i);
    end
  endgenerate

  // Scan from the top index down so the lowest matching index is kept.
  always_comb begin
    hit_o  = 1'b0;
    tile_o = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit_o  = 1'b1;
        tile_o = spr_tile_i[k*16 +: 16];
      end
    end
  end

endmodule

// File: rtl/tile_layer_renderer.sv
// Frame-at-a-time tile renderer: walks the map, substitutes sprite tiles
// with colour-key fallback to the map texel, and streams every pixel to
// the frame buffer through a ready/valid write port.
module tile_layer_renderer
  import render_pkg::*;
#(
  parameter int               MAP_W       = 16,
  parameter int               MAP_H       = 12,
  parameter int               GRID_BITS   = 4,
  parameter int               TILE        = 32,
  parameter int               TILE_BITS   = 5,
  parameter int               FB_W        = 640,
  parameter int               NUM_SPRITES = 4,
  parameter int               PIX_W       = 16,
  parameter logic [PIX_W-1:0] KEY_COLOUR  = PIX_W'(DEFAULT_KEY_COLOUR),
  parameter int               AW          = 19
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  input  logic [NUM_SPRITES-1:0]           spr_en,
  input  logic [NUM_SPRITES*GRID_BITS-1:0] spr_x,
  input  logic [NUM_SPRITES*GRID_BITS-1:0] spr_y,
  input  logic [NUM_SPRITES*16-1:0]        spr_tile,
  tile_layer_renderer_if.master            bus
);

  state_t                           state_q;
  logic [GRID_BITS-1:0]             gx_q, gy_q, gx_d, gy_d;
  logic [TILE_BITS-1:0]             px_q, py_q, px_d, py_d;
  logic [15:0]                      map_id_q, cell_id_q, cell_id_d;
  logic                             sprite_cell_q;
  logic [NUM_SPRITES-1:0]           spr_en_q;
  logic [NUM_SPRITES*GRID_BITS-1:0] spr_x_q, spr_y_q;
  logic [NUM_SPRITES*16-1:0]        spr_tile_q;
  logic                             busy_q, done_q, dst_wr_q;
  logic [AW-1:0]                    map_addr_q, tex_addr_q, dst_addr_q;
  logic [PIX_W-1:0]                 dst_data_q;

  logic                             hit;
  logic [15:0]                      hit_tile;
  logic                             pixel_last, cell_last, last_px, last_gx;
  logic [AW-1:0]                    sel_tex_addr, next_tex_addr, key_tex_addr;
  logic [AW-1:0]                    cur_dst_addr, next_map_addr;

  sprite_hit_select #(
    .NUM_SPRITES (NUM_SPRITES),
    .GRID_BITS   (GRID_BITS),
    .MAP_W       (MAP_W),
    .MAP_H       (MAP_H)
  ) u_hit (
    .spr_en_i   (spr_en_q),
    .spr_x_i    (spr_x_q),
    .spr_y_i    (spr_y_q),
    .spr_tile_i (spr_tile_q),
    .gx_i       (gx_q),
    .gy_i       (gy_q),
    .hit_o      (hit),
    .tile_o     (hit_tile)
  );

  // Scan-order successors and the addresses the FSM loads on each transition.
  always_comb begin
    last_px    = (px_q == TILE_BITS'(TILE - 1));
    last_gx    = (gx_q == GRID_BITS'(MAP_W - 1));
    pixel_last = last_px && (py_q == TILE_BITS'(TILE - 1));
    cell_last  = last_gx && (gy_q == GRID_BITS'(MAP_H - 1));
    // TILE is a power of two, so px/py wrap to zero on their own.
    px_d       = px_q + 1'b1;
    py_d       = last_px ? py_q + 1'b1 : py_q;
    gx_d       = last_gx ? '0 : gx_q + 1'b1;
    gy_d       = last_gx ? gy_q + 1'b1 : gy_q;
    cell_id_d  = hit ? hit_tile : map_id_q;

    sel_tex_addr  = AW'(tex_addr_calc(32'(cell_id_d), 32'(py_q), 32'(px_q), TILE_BITS));
    next_tex_addr = AW'(tex_addr_calc(32'(cell_id_q), 32'(py_d), 32'(px_d), TILE_BITS));
    key_tex_addr  = AW'(tex_addr_calc(32'(map_id_q), 32'(py_q), 32'(px_q), TILE_BITS));
    cur_dst_addr  = AW'(dst_addr_calc(32'(gx_q), 32'(gy_q), 32'(px_q), 32'(py_q),
                                      TILE_BITS, FB_W));
    next_map_addr = AW'(32'(gy_d) * 32'(MAP_W) + 32'(gx_d));
  end

  // Render FSM with all bus outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gx_q          <= '0;
      gy_q          <= '0;
      px_q          <= '0;
      py_q          <= '0;
      map_id_q      <= '0;
      cell_id_q     <= '0;
      sprite_cell_q <= 1'b0;
      spr_en_q      <= '0;
      spr_x_q       <= '0;
      spr_y_q       <= '0;
      spr_tile_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      dst_wr_q      <= 1'b0;
      map_addr_q    <= '0;
      tex_addr_q    <= '0;
      dst_addr_q    <= '0;
      dst_data_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // Sprite state is frozen for the whole frame.
            spr_en_q   <= spr_en;
            spr_x_q    <= spr_x;
            spr_y_q    <= spr_y;
            spr_tile_q <= spr_tile;
            gx_q       <= '0;
            gy_q       <= '0;
            px_q       <= '0;
            py_q       <= '0;
            map_addr_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_MAP_REQ;
          end
        end
        S_MAP_REQ: state_q <= S_MAP_WAIT;
        S_MAP_WAIT: begin
          map_id_q <= bus.map_data;
          state_q  <= S_SPR_SEL;
        end
        S_SPR_SEL: begin
          cell_id_q     <= cell_id_d;
          sprite_cell_q <= hit;
          tex_addr_q    <= sel_tex_addr;
          state_q       <= S_TEX_REQ;
        end
        S_TEX_REQ: state_q <= S_TEX_WAIT;
        S_TEX_WAIT: begin
          if (sprite_cell_q && (bus.tex_data == KEY_COLOUR)) begin
            // Transparent sprite texel: fetch the map tile underneath.
            tex_addr_q <= key_tex_addr;
            state_q    <= S_KEY_REQ;
          end else begin
            dst_data_q <= bus.tex_data;
            dst_addr_q <= cur_dst_addr;
            dst_wr_q   <= 1'b1;
            state_q    <= S_WRITE;
          end
        end
        S_KEY_REQ: state_q <= S_KEY_WAIT;
        S_KEY_WAIT: begin
          dst_data_q <= bus.tex_data;
          dst_addr_q <= cur_dst_addr;
          dst_wr_q   <= 1'b1;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          // Address and data hold until the frame buffer takes the pixel.
          if (bus.dst_ready) begin
            dst_wr_q <= 1'b0;
            px_q     <= px_d;
            py_q     <= py_d;
            if (!pixel_last) begin
              tex_addr_q <= next_tex_addr;
              state_q    <= S_TEX_REQ;
            end else if (!cell_last) begin
              gx_q       <= gx_d;
              gy_q       <= gy_d;
              map_addr_q <= next_map_addr;
              state_q    <= S_MAP_REQ;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.map_addr = map_addr_q;
  assign bus.tex_addr = tex_addr_q;
  assign bus.dst_addr = dst_addr_q;
  assign bus.dst_data = dst_data_q;
  assign bus.dst_wr   = dst_wr_q;

endmodule

// File: doc/tile_layer_renderer.md
Name: tile_layer_renderer

Overview:
Frame-at-a-time tile renderer. It walks every map cell, fetches the tile id from map BRAM and overlays up to NUM_SPRITES sprite tiles using colour-key transparency. It writes every pixel into the VGA frame buffer through a ready/valid write port. This block generalises the single-hero tile substitution: map size, tile size, sprite count and key colour are parameters, and the block adds start/done control and frame-buffer backpressure.

Parameters:
MAP_W, 16, map width in cells
MAP_H, 12, map height in cells
GRID_BITS, 4, width of one grid coordinate
TILE, 32, tile edge in pixels (power of two)
TILE_BITS, 5, log2(TILE)
FB_W, 640, frame-buffer line stride in pixels
NUM_SPRITES, 4, sprite overlay channels
PIX_W, 16, pixel word width
KEY_COLOUR, 16'hF81F, transparent sprite texel value
AW, 19, address width (map, texture, frame buffer)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins one frame render
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last pixel write is accepted
spr_en  in  NUM_SPRITES  per-sprite enable
spr_x  in  NUM_SPRITES*GRID_BITS  sprite cell x, packed, sprite 0 in LSBs
spr_y  in  NUM_SPRITES*GRID_BITS  sprite cell y, packed
spr_tile  in  NUM_SPRITES*16  sprite tile id, packed
map_addr  out  AW  map BRAM address = gy*MAP_W+gx
map_data  in  16  tile id; valid exactly 1 cycle after map_addr
tex_addr  out  AW  texel address = id*TILE*TILE + py*TILE + px
tex_data  in  PIX_W  texel; valid exactly 1 cycle after tex_addr
dst_addr  out  AW  frame-buffer address = (gy*TILE+py)*FB_W + gx*TILE+px
dst_data  out  PIX_W  pixel to write
dst_wr  out  1  write valid
dst_ready  in  1  frame buffer accepts the write

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0. The state machine returns to IDLE and counters gx, gy, px, py clear. Asserting rst mid-frame aborts the frame with no done pulse.
- States: IDLE -> MAP_REQ -> MAP_WAIT -> SPR_SEL -> TEX_REQ -> TEX_WAIT -> [KEY_REQ -> KEY_WAIT] -> WRITE -> (next pixel TEX_REQ | next cell MAP_REQ | DONE) -> IDLE.
- IDLE: when start=1, snapshot all spr_* inputs into internal registers, clear the counters and set busy. While busy=1, start is ignored. Sprite input changes mid-frame have no effect.
- MAP_REQ: drive map_addr. MAP_WAIT: capture map_data as map_id.
- SPR_SEL: hit = the lowest-index k with spr_en[k] && spr_x[k]==gx && spr_y[k]==gy. Sprite coordinates at or beyond MAP_W/MAP_H never hit. On a hit, cell_id = spr_tile[k] and sprite_cell=1. Otherwise cell_id = map_id and sprite_cell=0.
- TEX_REQ: tex_addr is computed from cell_id. TEX_WAIT: capture tex_data.
  - If sprite_cell=1 and texel==KEY_COLOUR, go to KEY_REQ. KEY_REQ refetches using map_id, and KEY_WAIT captures that texel as the pixel.
  - Otherwise the captured texel is the pixel.
  - A map texel equal to KEY_COLOUR is written unchanged.
- WRITE: dst_wr=1, with dst_addr and dst_data held stable until the cycle where dst_ready=1. The transfer occurs on that edge, and dst_wr drops the next cycle unless the next pixel is already in WRITE (it cannot be; minimum gap is 2 cycles).
- Scan order: px fastest, then py, then gx, then gy. Last write = cell (MAP_W-1, MAP_H-1), pixel (TILE-1, TILE-1).
- Cycle cost with dst_ready held high:
  - 3 cycles per cell overhead.
  - 3 cycles per opaque pixel.
  - 5 cycles per keyed sprite pixel.
- done=1 for exactly the cycle after the final accepted write. busy falls in that same cycle, and the FSM is back in IDLE. A start in the done cycle is accepted.
- Arithmetic: all addresses are computed in AW bits, with results truncated to AW. Products use shifts by TILE_BITS. The FB_W multiply is a constant multiply.

Decomposition:
- Package render_pkg holds:
  - state encoding localparams
  - the default KEY_COLOUR
  - address-composition functions for tex_addr and dst_addr
- Sub-module sprite_hit_select: combinational priority match over NUM_SPRITES. Inputs are the snapshot vectors plus gx/gy; outputs are hit and tile id. This is the only natural split; it is tested standalone.

Test Plan:
Bench parameters: MAP_W=2, MAP_H=2, TILE=2, FB_W=4, NUM_SPRITES=2. Map ids are {0,1,2,3}. Texture ROM: texel = id*16+index, except id 5 index 0 = KEY_COLOUR.
- No sprites, dst_ready=1, start pulse -> 16 writes in scan order. The first three writes are (addr 0, 0x00), (1, 0x01), (4, 0x02). done occurs exactly 1 cycle after the 16th write, and total busy cycles = 4*3 + 16*3 = 60.
- Sprite 0 enabled at (1,0), tile 5 -> cell (1,0) pixel 0 writes the map texel 0x10 to addr 2. Its other pixels write 0x51..0x53. Cell cost is 3+5+3+3+3 cycles.
- Sprites 0 and 1 both at (0,1), tiles 6 and 7 -> sprite 0 wins, and cell (0,1) pixels write 0x60..0x63 at addrs 8, 9, 12, 13.
- dst_ready held low for 5 cycles on the 3rd write -> dst_addr and dst_data stay stable all 5 cycles, there is no duplicate or dropped write, and the frame still completes with exactly 16 accepted writes.
- start pulsed mid-frame, and spr_x changed mid-frame -> both ignored, and output is identical to the snapshot frame. Then rst asserted mid-frame -> all outputs 0 immediately with no done pulse. A fresh start then renders a complete correct frame.
